// File: rtl/ahb_mst_arbiter_rr.sv
// N-master AHB round-robin arbiter with HLOCK ownership and split address/data muxing.
// Define AHB_ARB_TIMEOUT_EN to force rearbitration after MAX_HOLD beats of unlocked ownership.
module ahb_mst_arbiter_rr #(
    parameter int NUM_M     = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEFAULT_M = 0,
    parameter int MAX_HOLD  = 16,
    localparam int MW       = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [NUM_M-1:0]           HBUSREQ,
    input  logic [NUM_M-1:0]           HLOCK,
    input  logic [NUM_M*ADDR_W-1:0]    HADDR_M,
    input  logic [NUM_M*2-1:0]         HTRANS_M,
    input  logic [NUM_M*3-1:0]         HSIZE_M,
    input  logic [NUM_M-1:0]           HWRITE_M,
    input  logic [NUM_M*DATA_W-1:0]    HWDATA_M,
    input  logic                       HREADY,
    output logic [NUM_M-1:0]           HGRANT,
    output logic [MW-1:0]              HMASTER,
    output logic                       HMASTLOCK,
    output logic [ADDR_W-1:0]          HADDR_S,
    output logic [1:0]                 HTRANS_S,
    output logic [2:0]                 HSIZE_S,
    output logic                       HWRITE_S,
    output logic [DATA_W-1:0]          HWDATA_S
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_LOCKED} state_t;

    localparam logic [MW-1:0]    DEF_IDX   = MW'(DEFAULT_M);
    localparam logic [NUM_M-1:0] GRANT_RST = NUM_M'(1) << DEFAULT_M;

    if (NUM_M < 2 || NUM_M > 8 || DEFAULT_M < 0 || DEFAULT_M >= NUM_M || MAX_HOLD < 1) begin : g_paramCheck
        $error("ahb_mst_arbiter_rr: illegal parameter combination");
    end

    state_t             r_state;
    state_t             w_nextState;
    logic [NUM_M-1:0]   r_grant;
    logic [NUM_M-1:0]   w_nextGrant;
    logic [MW-1:0]      r_master;
    logic [MW-1:0]      r_masterD;
    logic               r_mastLock;
    logic [MW-1:0]      w_owner;
    logic [MW-1:0]      w_pick;
    logic [MW-1:0]      w_nextIdx;
    logic               w_pickValid;
    logic               w_rearb;
    logic               w_forceRearb;
    logic [NUM_M-1:0]   w_reqRot;
    int                 w_pickSum;

    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_grant[i]) w_owner = MW'(i);
        end
    end

    // Rotate requests so bit 0 is the master after the owner; the owner itself lands last.
    always_comb begin
        w_reqRot    = NUM_M'({HBUSREQ, HBUSREQ} >> (int'(w_owner) + 1));
        w_pickSum   = 0;
        w_pickValid = 1'b0;
        for (int j = NUM_M - 1; j >= 0; j--) begin
            if (w_reqRot[j]) begin
                w_pickSum   = int'(w_owner) + 1 + j;
                w_pickValid = 1'b1;
            end
        end
        if (w_pickSum >= NUM_M) w_pickSum = w_pickSum - NUM_M;
        w_pick = MW'(w_pickSum);
    end

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] r_holdCnt;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_holdCnt <= '0;
        end else if (HREADY) begin
            if (r_state == ST_GRANTED && w_nextIdx == w_owner) begin
                if (r_holdCnt != CW'(MAX_HOLD - 1)) r_holdCnt <= r_holdCnt + 1'b1;
            end else begin
                r_holdCnt <= '0;
            end
        end
    end

    assign w_forceRearb = (r_state == ST_GRANTED) && (r_holdCnt == CW'(MAX_HOLD - 1))
                          && (|(HBUSREQ & ~r_grant));
`else
    assign w_forceRearb = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = w_owner;
        w_rearb     = 1'b0;
        case (r_state)
            ST_IDLE:    w_rearb = 1'b1;
            ST_GRANTED: begin
                if (HLOCK[w_owner])                          w_nextState = ST_LOCKED;
                else if (!HBUSREQ[w_owner] || w_forceRearb)  w_rearb = 1'b1;
            end
            ST_LOCKED:  begin
                if (!HLOCK[w_owner] && !HBUSREQ[w_owner])    w_rearb = 1'b1;
            end
            default:    w_nextState = ST_IDLE;
        endcase
        // Only a pick made from IDLE enters LOCKED directly; a locked pick from GRANTED locks one beat later.
        if (w_rearb) begin
            if (w_pickValid) begin
                w_nextIdx   = w_pick;
                w_nextState = (r_state == ST_IDLE && HLOCK[w_pick]) ? ST_LOCKED : ST_GRANTED;
            end else begin
                w_nextIdx   = DEF_IDX;
                w_nextState = ST_IDLE;
            end
        end
    end

    always_comb begin
        w_nextGrant = '0;
        for (int i = 0; i < NUM_M; i++) begin
            w_nextGrant[i] = (w_nextIdx == MW'(i));
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_grant    <= GRANT_RST;
            r_master   <= DEF_IDX;
            r_masterD  <= DEF_IDX;
            r_mastLock <= 1'b0;
        end else if (HREADY) begin
            r_state    <= w_nextState;
            r_grant    <= w_nextGrant;
            r_master   <= w_owner;
            r_masterD  <= r_master;
            r_mastLock <= HLOCK[w_owner];
        end
    end

    always_comb begin
        HADDR_S  = HADDR_M[ADDR_W-1:0];
        HTRANS_S = HTRANS_M[1:0];
        HSIZE_S  = HSIZE_M[2:0];
        HWRITE_S = HWRITE_M[0];
        HWDATA_S = HWDATA_M[DATA_W-1:0];
        for (int i = 0; i < NUM_M; i++) begin
            if (r_master == MW'(i)) begin
                HADDR_S  = HADDR_M[i*ADDR_W +: ADDR_W];
                HTRANS_S = HTRANS_M[i*2 +: 2];
                HSIZE_S  = HSIZE_M[i*3 +: 3];
                HWRITE_S = HWRITE_M[i];
            end
            if (r_masterD == MW'(i)) HWDATA_S = HWDATA_M[i*DATA_W +: DATA_W];
        end
        if (HRESET) HTRANS_S = 2'b00;
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastLock;

endmodule

// File: tb/tb_ahb_mst_arbiter_rr.sv
// Bench for ahb_mst_arbiter_rr: directed vector table, reset/stall sequences, then random
// traffic checked against an integer-level arbitration model.
module tb_ahb_mst_arbiter_rr;

    localparam int NUM_M     = 3;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int DEFAULT_M = 0;
    localparam int MW        = 2;
    localparam int S_IDLE    = 0;
    localparam int S_GRANTED = 1;
    localparam int S_LOCKED  = 2;

    logic                    HCLK = 1'b0;
    logic                    HRESET;
    logic [NUM_M-1:0]        HBUSREQ;
    logic [NUM_M-1:0]        HLOCK;
    logic [NUM_M*ADDR_W-1:0] HADDR_M;
    logic [NUM_M*2-1:0]      HTRANS_M;
    logic [NUM_M*3-1:0]      HSIZE_M;
    logic [NUM_M-1:0]        HWRITE_M;
    logic [NUM_M*DATA_W-1:0] HWDATA_M;
    logic                    HREADY;
    logic [NUM_M-1:0]        HGRANT;
    logic [MW-1:0]           HMASTER;
    logic                    HMASTLOCK;
    logic [ADDR_W-1:0]       HADDR_S;
    logic [1:0]              HTRANS_S;
    logic [2:0]              HSIZE_S;
    logic                    HWRITE_S;
    logic [DATA_W-1:0]       HWDATA_S;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] addrArr  [NUM_M];
    logic [DATA_W-1:0] wdataArr [NUM_M];
    logic [1:0]        transArr [NUM_M];
    logic [2:0]        sizeArr  [NUM_M];
    logic              writeArr [NUM_M];

    int   mGrant, mMaster, mMasterD, mState;
    logic mLock;

    typedef struct {
        logic [NUM_M-1:0] req;
        logic [NUM_M-1:0] lck;
        logic             rdy;
        logic [NUM_M-1:0] expGrant;
        int               expMaster;
        int               expMd;
        logic             expLock;
    } vec_t;

    vec_t vecQ[$];

    ahb_mst_arbiter_rr #(
        .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEFAULT_M(DEFAULT_M), .MAX_HOLD(16)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HSIZE_M(HSIZE_M), .HWRITE_M(HWRITE_M),
        .HWDATA_M(HWDATA_M), .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
        .HMASTLOCK(HMASTLOCK), .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HSIZE_S(HSIZE_S),
        .HWRITE_S(HWRITE_S), .HWDATA_S(HWDATA_S)
    );

    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic packInputs();
        for (int i = 0; i < NUM_M; i++) begin
            HADDR_M[i*ADDR_W +: ADDR_W]  = addrArr[i];
            HWDATA_M[i*DATA_W +: DATA_W] = wdataArr[i];
            HTRANS_M[i*2 +: 2]           = transArr[i];
            HSIZE_M[i*3 +: 3]            = sizeArr[i];
            HWRITE_M[i]                  = writeArr[i];
        end
    endtask

    task automatic fixedData();
        for (int i = 0; i < NUM_M; i++) begin
            addrArr[i]  = 32'hA000_0000 + 32'(i);
            wdataArr[i] = 32'hD000_0000 + 32'(i);
            transArr[i] = 2'b10;
            sizeArr[i]  = 3'b010;
            writeArr[i] = 1'(i % 2);
        end
    endtask

    task automatic randomData();
        for (int i = 0; i < NUM_M; i++) begin
            addrArr[i]  = $urandom;
            wdataArr[i] = $urandom;
            transArr[i] = 2'($urandom_range(0, 3));
            sizeArr[i]  = 3'($urandom_range(0, 7));
            writeArr[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic resetModel();
        mGrant   = DEFAULT_M;
        mMaster  = DEFAULT_M;
        mMasterD = DEFAULT_M;
        mLock    = 1'b0;
        mState   = S_IDLE;
    endtask

    // First requester after the owner in circular order, owner considered last; -1 if none.
    function automatic int rrPick(input int owner, input logic [NUM_M-1:0] req);
        for (int k = 1; k <= NUM_M; k++) begin
            int c;
            c = (owner + k) % NUM_M;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelEdge(input logic [NUM_M-1:0] req, input logic [NUM_M-1:0] lck);
        int  p;
        bit  rearb;
        mMasterD = mMaster;
        mMaster  = mGrant;
        mLock    = lck[mGrant];
        rearb    = 0;
        if (mState == S_IDLE) rearb = 1;
        else if (mState == S_GRANTED) begin
            if (lck[mGrant]) mState = S_LOCKED;
            else if (!req[mGrant]) rearb = 1;
        end else if (!lck[mGrant] && !req[mGrant]) rearb = 1;
        if (rearb) begin
            p = rrPick(mGrant, req);
            if (p < 0) begin
                mGrant = DEFAULT_M;
                mState = S_IDLE;
            end else begin
                mState = (mState == S_IDLE && lck[p]) ? S_LOCKED : S_GRANTED;
                mGrant = p;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NUM_M-1:0] req, input logic [NUM_M-1:0] lck,
                                 input logic rdy, input bit newData);
        HBUSREQ = req;
        HLOCK   = lck;
        HREADY  = rdy;
        if (newData) randomData();
        packInputs();
        @(posedge HCLK);
        if (rdy && !HRESET) modelEdge(req, lck);
        #1;
    endtask

    task automatic checkModel();
        checkOutput("grant",    64'(HGRANT),    64'(NUM_M'(1) << mGrant));
        checkOutput("master",   64'(HMASTER),   64'(mMaster));
        checkOutput("mastlock", 64'(HMASTLOCK), 64'(mLock));
        checkOutput("haddr",    64'(HADDR_S),   64'(addrArr[mMaster]));
        checkOutput("htrans",   64'(HTRANS_S),  64'(transArr[mMaster]));
        checkOutput("hsize",    64'(HSIZE_S),   64'(sizeArr[mMaster]));
        checkOutput("hwrite",   64'(HWRITE_S),  64'(writeArr[mMaster]));
        checkOutput("hwdata",   64'(HWDATA_S),  64'(wdataArr[mMasterD]));
    endtask

    task automatic addVec(input logic [NUM_M-1:0] req, input logic [NUM_M-1:0] lck, input logic rdy,
                          input logic [NUM_M-1:0] g, input int m, input int md, input logic l);
        vec_t v;
        v.req = req; v.lck = lck; v.rdy = rdy;
        v.expGrant = g; v.expMaster = m; v.expMd = md; v.expLock = l;
        vecQ.push_back(v);
    endtask

    initial begin
        // Directed sequence from reset: handover, wrap-around, locked ownership, HREADY stalls.
        addVec(3'b000, 3'b000, 1'b1, 3'b001, 0, 0, 1'b0);
        addVec(3'b110, 3'b000, 1'b1, 3'b010, 0, 0, 1'b0);
        addVec(3'b100, 3'b000, 1'b1, 3'b100, 1, 0, 1'b0);
        addVec(3'b100, 3'b000, 1'b1, 3'b100, 2, 1, 1'b0);
        addVec(3'b111, 3'b000, 1'b1, 3'b100, 2, 2, 1'b0);
        addVec(3'b111, 3'b000, 1'b1, 3'b100, 2, 2, 1'b0);
        addVec(3'b011, 3'b000, 1'b1, 3'b001, 2, 2, 1'b0);
        addVec(3'b011, 3'b000, 1'b1, 3'b001, 0, 2, 1'b0);
        addVec(3'b010, 3'b000, 1'b1, 3'b010, 0, 0, 1'b0);
        addVec(3'b010, 3'b010, 1'b1, 3'b010, 1, 0, 1'b1);
        addVec(3'b111, 3'b010, 1'b0, 3'b010, 1, 0, 1'b1);
        addVec(3'b111, 3'b010, 1'b1, 3'b010, 1, 1, 1'b1);
        addVec(3'b111, 3'b010, 1'b0, 3'b010, 1, 1, 1'b1);
        addVec(3'b111, 3'b010, 1'b1, 3'b010, 1, 1, 1'b1);
        addVec(3'b101, 3'b000, 1'b1, 3'b100, 1, 1, 1'b0);
        addVec(3'b101, 3'b000, 1'b1, 3'b100, 2, 1, 1'b0);
        addVec(3'b011, 3'b000, 1'b0, 3'b100, 2, 1, 1'b0);
        addVec(3'b001, 3'b001, 1'b0, 3'b100, 2, 1, 1'b0);
        addVec(3'b010, 3'b000, 1'b0, 3'b100, 2, 1, 1'b0);
        addVec(3'b000, 3'b100, 1'b0, 3'b100, 2, 1, 1'b0);
        addVec(3'b111, 3'b010, 1'b0, 3'b100, 2, 1, 1'b0);
        addVec(3'b000, 3'b000, 1'b1, 3'b001, 2, 2, 1'b0);
        addVec(3'b000, 3'b000, 1'b1, 3'b001, 0, 2, 1'b0);
        addVec(3'b001, 3'b000, 1'b1, 3'b001, 0, 0, 1'b0);

        HRESET  = 1'b1;
        HBUSREQ = '0;
        HLOCK   = '0;
        HREADY  = 1'b1;
        fixedData();
        packInputs();
        resetModel();
        repeat (2) @(posedge HCLK);
        #1;
        checkOutput("rst_grant",    64'(HGRANT),    64'(3'b001));
        checkOutput("rst_master",   64'(HMASTER),   64'(0));
        checkOutput("rst_mastlock", 64'(HMASTLOCK), 64'(0));
        checkOutput("rst_htrans",   64'(HTRANS_S),  64'(2'b00));
        HRESET = 1'b0;

        foreach (vecQ[n]) begin
            applyStimulus(vecQ[n].req, vecQ[n].lck, vecQ[n].rdy, 1'b0);
            checkOutput($sformatf("vec%0d_grant", n),    64'(HGRANT),    64'(vecQ[n].expGrant));
            checkOutput($sformatf("vec%0d_master", n),   64'(HMASTER),   64'(vecQ[n].expMaster));
            checkOutput($sformatf("vec%0d_mastlock", n), 64'(HMASTLOCK), 64'(vecQ[n].expLock));
            checkOutput($sformatf("vec%0d_haddr", n),    64'(HADDR_S),   64'(addrArr[vecQ[n].expMaster]));
            checkOutput($sformatf("vec%0d_hwdata", n),   64'(HWDATA_S),  64'(wdataArr[vecQ[n].expMd]));
        end

        // Move ownership to M2, then assert reset between edges.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3'b100, 3'b000, 1'b1, 1'b0);
            checkModel();
        end
        #2;
        HRESET = 1'b1;
        #1;
        checkOutput("midrst_grant",    64'(HGRANT),    64'(3'b001));
        checkOutput("midrst_master",   64'(HMASTER),   64'(0));
        checkOutput("midrst_mastlock", 64'(HMASTLOCK), 64'(0));
        checkOutput("midrst_htrans",   64'(HTRANS_S),  64'(2'b00));
        resetModel();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        for (int c = 0; c < 400; c++) begin
            logic [NUM_M-1:0] req;
            logic [NUM_M-1:0] lck;
            req = NUM_M'($urandom_range(0, 7));
            lck = '0;
            for (int i = 0; i < NUM_M; i++) begin
                if ($urandom_range(0, 5) == 0) lck[i] = 1'b1;
            end
            applyStimulus(req, lck, ($urandom_range(0, 3) != 0), 1'b1);
            checkModel();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
